// File: rtl/div_sched_pkg.sv
// rtl/div_sched_pkg.sv - shared types, defaults and half-period clamp for the divider scheduler
package div_sched_pkg;

    typedef enum logic [1:0] {IDLE, RUN, PEND} div_state_t;

    localparam int DIV_CW_DEF   = 8;
    localparam int DIV_DEF_HALF = 8;

    // A zero half-period would stall the counter, so it is promoted to the fastest legal ratio.
    function automatic logic [31:0] clamp_half(input logic [31:0] half);
        return (half == 32'd0) ? 32'd1 : half;
    endfunction

endpackage

// File: rtl/div_ratio_sched_rr_arb.sv
// rtl/div_ratio_sched_rr_arb.sv - round-robin arbiter: request vector and pointer to one-hot grant and next pointer
module rr_arb #(
    parameter int N  = 2,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic [PW-1:0] nxt_ptr
);

    logic found;
    int   idx;

    // Scan from the pointer position so the last winner gets lowest priority next time.
    always_comb begin
        gnt     = '0;
        nxt_ptr = ptr;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req[idx]) begin
                gnt[idx] = 1'b1;
                nxt_ptr  = PW'((idx + 1) % N);
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/div_ratio_sched.sv
// rtl/div_ratio_sched.sv - shared clock-divider ratio scheduler with glitch-free apply at falling boundaries
// Optional DIV_SCHED_STATS_EN adds the upd_cnt and stall status outputs.
module div_ratio_sched
    import div_sched_pkg::*;
#(
    parameter int NREQ     = 2,
    parameter int CW       = DIV_CW_DEF,
    parameter int DEF_HALF = DIV_DEF_HALF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               en,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*CW-1:0] req_half,
    output logic [NREQ-1:0]    req_ready,
    output logic               out_div,
    output logic               tick,
    output logic [CW-1:0]      cur_half,
    output logic               pend
`ifdef DIV_SCHED_STATS_EN
    ,
    output logic [7:0]         upd_cnt,
    output logic [0:0]         stall
`endif
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    div_state_t      state, state_nxt;
    logic [CW-1:0]   ctr;
    logic [CW-1:0]   pend_half;
    logic [CW-1:0]   sel_half;
    logic [PW-1:0]   ptr, nxt_ptr;
    logic [NREQ-1:0] gnt;
    logic            arb_on, tc, grant, apply;

    rr_arb #(.N(NREQ), .PW(PW)) u_arb (
        .req     (req_valid),
        .ptr     (ptr),
        .gnt     (gnt),
        .nxt_ptr (nxt_ptr)
    );

    always_comb begin
        sel_half = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) sel_half = req_half[i*CW +: CW];
        end
    end

    // Only an idle-pipeline RUN accepts a new ratio; everything else back-pressures.
    assign arb_on    = (state == RUN) && !pend;
    assign req_ready = arb_on ? gnt : '0;
    assign grant     = arb_on && (|req_valid);
    assign tc        = (state != IDLE) && (ctr == cur_half - CW'(1));
    assign tick      = en && tc;
    // Applying only on the high-phase terminal count keeps every half-period whole.
    assign apply     = en && (state == PEND) && tc && out_div;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (!en) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = pend ? PEND : RUN;
                RUN:     if (grant) state_nxt = PEND;
                PEND:    if (apply) state_nxt = RUN;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctr       <= '0;
            out_div   <= 1'b0;
            cur_half  <= CW'(DEF_HALF);
            pend      <= 1'b0;
            pend_half <= CW'(DEF_HALF);
            ptr       <= '0;
        end else begin
            if (!en || state == IDLE) begin
                ctr     <= '0;
                out_div <= 1'b0;
            end else if (tc) begin
                ctr     <= '0;
                out_div <= ~out_div;
            end else begin
                ctr <= ctr + CW'(1);
            end

            // Pending ratio survives en drops; it is consumed only by a real falling boundary.
            if (grant) begin
                pend      <= 1'b1;
                pend_half <= CW'(clamp_half(32'(sel_half)));
                ptr       <= nxt_ptr;
            end else if (apply) begin
                pend     <= 1'b0;
                cur_half <= pend_half;
            end
        end
    end

`ifdef DIV_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            upd_cnt <= 8'd0;
        end else if (apply && upd_cnt != 8'hff) begin
            upd_cnt <= upd_cnt + 8'd1;
        end
    end

    assign stall = |(req_valid & ~req_ready);
`endif

endmodule

// File: tb/tb_div_ratio_sched.sv
// tb/tb_div_ratio_sched.sv - directed bench with cycle model for div_ratio_sched
module tb_div_ratio_sched;

    localparam int NREQ = 2;
    localparam int CW   = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               en;
    logic [NREQ-1:0]    req_valid;
    logic [NREQ*CW-1:0] req_half;
    logic [NREQ-1:0]    req_ready;
    logic               out_div;
    logic               tick;
    logic [CW-1:0]      cur_half;
    logic               pend;
`ifdef DIV_SCHED_STATS_EN
    logic [7:0]         upd_cnt;
    logic [0:0]         stall;
`endif

    int checks = 0;
    int errors = 0;

    div_ratio_sched #(.NREQ(NREQ), .CW(CW), .DEF_HALF(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .req_valid (req_valid),
        .req_half  (req_half),
        .req_ready (req_ready),
        .out_div   (out_div),
        .tick      (tick),
        .cur_half  (cur_half),
        .pend      (pend)
`ifdef DIV_SCHED_STATS_EN
        ,
        .upd_cnt   (upd_cnt),
        .stall     (stall)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Spec-level model: divider phase position, output level, ratio in force, pending ratio, RR pointer.
    int m_ok = 0, m_active, m_cnt, m_lvl, m_half, m_pend, m_phalf, m_ptr, m_upd;
    int mw, m_rh, m_oldpend, m_exp_tick;
    logic [NREQ-1:0] m_exp_ready;

    function automatic int exp_win();
        if (m_active == 0 || m_pend != 0) return -1;
        for (int k = 0; k < NREQ; k++) begin
            if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
        end
        return -1;
    endfunction

    initial forever begin
        @(negedge clk);
        mw = exp_win();
        m_exp_ready = '0;
        if (mw >= 0) m_exp_ready[mw] = 1'b1;
        m_exp_tick = (en && m_active != 0 && m_cnt == m_half - 1) ? 1 : 0;
        if (m_ok != 0 && !reset) begin
            chk("m_out_div", int'(out_div), m_lvl);
            chk("m_tick", int'(tick), m_exp_tick);
            chk("m_cur_half", int'(cur_half), m_half);
            chk("m_pend", int'(pend), m_pend);
            chk("m_req_ready", int'(req_ready), int'(m_exp_ready));
`ifdef DIV_SCHED_STATS_EN
            chk("m_upd_cnt", int'(upd_cnt), m_upd);
            chk("m_stall", int'(stall), int'(|(req_valid & ~m_exp_ready)));
`endif
        end
        if (reset) begin
            m_ok = 1; m_active = 0; m_cnt = 0; m_lvl = 0; m_half = 8;
            m_pend = 0; m_phalf = 8; m_ptr = 0; m_upd = 0;
        end else if (m_ok != 0) begin
            m_oldpend = m_pend;
            if (!en) begin
                m_active = 0; m_cnt = 0; m_lvl = 0;
            end else if (m_active == 0) begin
                m_active = 1;
            end else if (m_cnt == m_half - 1) begin
                m_cnt = 0;
                if (m_lvl == 1 && m_oldpend != 0) begin
                    m_half = m_phalf;
                    m_pend = 0;
                    if (m_upd < 255) m_upd++;
                end
                m_lvl = 1 - m_lvl;
            end else begin
                m_cnt++;
            end
            if (mw >= 0) begin
                m_rh     = int'(req_half[mw*CW +: CW]);
                m_pend   = 1;
                m_phalf  = (m_rh == 0) ? 1 : m_rh;
                m_ptr    = (mw + 1) % NREQ;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    // Masters drop valid after the cycle in which they saw ready.
    task automatic cycle_hs();
        logic [NREQ-1:0] acc;
        acc = req_valid & req_ready;
        cyc();
        req_valid = req_valid & ~acc;
        #1;
    endtask

    task automatic wait_tick(input int bound, output int n);
        n = 0;
        while (!tick && n < bound) begin
            cyc();
            n++;
        end
    endtask

    task automatic wait_pend_clear(input int bound);
        int n;
        n = 0;
        while (pend && n < bound) begin
            cycle_hs();
            n++;
        end
        chk("pend_clear_timeout", int'(pend), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, t, prev;
        reset = 1'b1; en = 1'b0; req_valid = '0; req_half = '0;
        repeat (3) cyc();
        reset = 1'b0;
        #1;
        chk("rst_out_div", int'(out_div), 0);
        chk("rst_tick", int'(tick), 0);
        chk("rst_cur_half", int'(cur_half), 8);
        chk("rst_pend", int'(pend), 0);
        chk("rst_req_ready", int'(req_ready), 0);

        // Divide-by-16 default: one idle cycle, then a tick every 8 clocks.
        en = 1'b1;
        wait_tick(64, n);
        chk("first_tick_delay", n, 8);
        cyc(); wait_tick(64, n);
        chk("tick_gap_a", n, 7);
        cyc(); wait_tick(64, n);
        chk("tick_gap_b", n, 7);
        chk("def_cur_half", int'(cur_half), 8);

        // Two simultaneous requests, served in RR order starting at requester 0.
        req_half = {8'd5, 8'd4};
        req_valid = 2'b11;
        #1;
        chk("rr_first", int'(req_ready), 1);
        cycle_hs();
        chk("rr_pend", int'(pend), 1);
        chk("rr_stall_ready", int'(req_ready), 0);
        wait_pend_clear(64);
        chk("rr_half4", int'(cur_half), 4);
        chk("rr_second", int'(req_ready), 2);
        cycle_hs();
        wait_pend_clear(64);
        chk("rr_half5", int'(cur_half), 5);
        req_valid = 2'b11;
        #1;
        chk("rr_ptr_wrap", int'(req_ready), 1);
        req_valid = 2'b00;

        // Request during the high phase: current period completes before half=3 takes over.
        n = 0;
        while (!(tick && !out_div) && n < 64) begin cyc(); n++; end
        chk("rise_found", int'(n < 64), 1);
        cyc(); cyc();
        req_half = 16'h0003;
        req_valid = 2'b01;
        #1;
        chk("h3_ready", int'(req_ready), 1);
        cycle_hs();
        chk("h3_pend", int'(pend), 1);
        chk("h3_old_kept", int'(cur_half), 5);
        wait_pend_clear(64);
        chk("h3_cur_half", int'(cur_half), 3);
        chk("h3_low_start", int'(out_div), 0);
        wait_tick(16, n);
        chk("h3_gap_a", n, 2);
        cyc(); wait_tick(16, n);
        chk("h3_gap_b", n, 2);

        // Zero request clamps to divide-by-2.
        req_half = 16'h0000;
        req_valid = 2'b01;
        #1;
        chk("h0_ready", int'(req_ready), 1);
        cycle_hs();
        wait_pend_clear(64);
        chk("h0_cur_half", int'(cur_half), 1);
        cyc();
        prev = int'(out_div);
        cyc();
        chk("h0_toggle", int'(out_div), 1 - prev);
        chk("h0_tick", int'(tick), 1);

        // Grant in the falling terminal-count cycle waits for the next falling boundary.
        if (!out_div) cyc();
        req_half = {8'd2, 8'd0};
        req_valid = 2'b10;
        #1;
        chk("tcg_ready", int'(req_ready), 2);
        chk("tcg_tick", int'(tick), 1);
        cycle_hs();
        chk("tcg_pend_a", int'(pend), 1);
        chk("tcg_out_a", int'(out_div), 0);
        cycle_hs();
        chk("tcg_pend_b", int'(pend), 1);
        chk("tcg_out_b", int'(out_div), 1);
        cycle_hs();
        chk("tcg_applied", int'(pend), 0);
        chk("tcg_cur_half", int'(cur_half), 2);

        // Reset with a ratio pending discards it.
        req_half = 16'h0006;
        req_valid = 2'b01;
        #1;
        chk("rp_ready", int'(req_ready), 1);
        cycle_hs();
        chk("rp_pend", int'(pend), 1);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        #1;
        chk("rp_cur_half", int'(cur_half), 8);
        chk("rp_pend_clr", int'(pend), 0);
        chk("rp_out_div", int'(out_div), 0);

        // en drop with a ratio pending: output forced low, ratio retained and applied after restart.
        n = 0;
        while (!out_div && n < 64) begin cyc(); n++; end
        req_half = 16'h0002;
        req_valid = 2'b01;
        #1;
        chk("en_ready", int'(req_ready), 1);
        cycle_hs();
        chk("en_pend", int'(pend), 1);
        en = 1'b0;
        cyc();
        chk("en_off_out", int'(out_div), 0);
        chk("en_off_pend", int'(pend), 1);
        chk("en_off_tick", int'(tick), 0);
        cyc(); cyc();
        chk("en_pend_kept", int'(pend), 1);
        chk("en_half_kept", int'(cur_half), 8);
        en = 1'b1;
        n = 0; t = 0;
        while (pend && n < 64) begin
            if (tick) t++;
            cyc();
            n++;
        end
        chk("en_apply_timeout", int'(pend), 0);
        chk("en_ticks_to_apply", t, 2);
        chk("en_cur_half", int'(cur_half), 2);
`ifdef DIV_SCHED_STATS_EN
        chk("upd_cnt_final", int'(upd_cnt), 1);
`endif
        cyc(); cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
